// File: rtl/conv_layer_seq_if.sv
// Bundles the command, weight-ROM and conv-engine signals of conv_layer_seq.
//   slave  : sequencer side (conv_layer_seq)
//   master : environment side (command source, weight ROM, conv engine)
// Ports:
//   cmd_valid/cmd_ready/cmd_layer        layer command handshake
//   busy/layer_done/err_timeout          sequencer status
//   wt_rd/wt_addr/wt_rdata               bit-serial weight ROM read
//   conv_state/conv_start/conv_weight_en/conv_weight/conv_done   engine control
interface conv_layer_seq_if #(
    parameter int unsigned NCH = 6,
    parameter int unsigned AW  = 10
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_layer;
    logic           busy;
    logic           layer_done;
    logic           err_timeout;
    logic           wt_rd;
    logic [AW-1:0]  wt_addr;
    logic           wt_rdata;
    logic           conv_state;
    logic           conv_start;
    logic [NCH-1:0] conv_weight_en;
    logic           conv_weight;
    logic [NCH-1:0] conv_done;

    modport slave (
        input  cmd_valid, cmd_layer, wt_rdata, conv_done,
        output cmd_ready, busy, layer_done, err_timeout,
               wt_rd, wt_addr, conv_state, conv_start, conv_weight_en, conv_weight
    );

    modport master (
        output cmd_valid, cmd_layer, wt_rdata, conv_done,
        input  cmd_ready, busy, layer_done, err_timeout,
               wt_rd, wt_addr, conv_state, conv_start, conv_weight_en, conv_weight
    );
endinterface

// File: rtl/conv_layer_seq.sv
// Sequencer for the 6-channel conv/relu/maxpool engine. Takes one layer command,
// streams NCH binary KBITS-bit kernels bit-serially from weight ROM into the engine,
// holds engine start until every channel reports done, drains, then pulses layer_done.
// A watchdog aborts a layer whose RUN phase exceeds TIMEOUT cycles (sticky err_timeout).
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous reset, active-high
//   bus   conv_layer_seq_if.slave: command handshake, status, ROM read, engine control
module conv_layer_seq #(
    parameter int unsigned NCH       = 6,
    parameter int unsigned KBITS     = 25,
    parameter int unsigned AW        = 10,
    parameter int unsigned L1_BASE   = 150,
    parameter int unsigned DRAIN_CYC = 16,
    parameter int unsigned TIMEOUT   = 4095
) (
    input  logic            clk,
    input  logic            rst,
    conv_layer_seq_if.slave bus
);
    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned B_W  = (KBITS > 1) ? $clog2(KBITS) : 1;
    localparam int unsigned WD_W = 16;
    localparam int unsigned DR_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [B_W-1:0]  b_q, b_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [DR_W-1:0] drain_q, drain_d;

    logic            cmd_ready_q, cmd_ready_d;
    logic            busy_q, busy_d;
    logic            layer_done_q, layer_done_d;
    logic            err_q, err_d;
    logic            wt_rd_q, wt_rd_d;
    logic [AW-1:0]   wt_addr_q, wt_addr_d;
    logic            conv_state_q, conv_state_d;
    logic            conv_start_q, conv_start_d;
    logic [NCH-1:0]  weight_en_q, weight_en_d;

    logic            last_bit;

    // (ch_q, b_q) names the kernel bit whose address is on wt_addr this cycle
    assign last_bit = (ch_q == CH_W'(NCH - 1)) && (b_q == B_W'(KBITS - 1));

    // State and registered-output update
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ch_q         <= '0;
            b_q          <= '0;
            wdog_q       <= '0;
            drain_q      <= '0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b0;
            err_q        <= 1'b0;
            wt_rd_q      <= 1'b0;
            wt_addr_q    <= '0;
            conv_state_q <= 1'b0;
            conv_start_q <= 1'b0;
            weight_en_q  <= '0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            b_q          <= b_d;
            wdog_q       <= wdog_d;
            drain_q      <= drain_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            layer_done_q <= layer_done_d;
            err_q        <= err_d;
            wt_rd_q      <= wt_rd_d;
            wt_addr_q    <= wt_addr_d;
            conv_state_q <= conv_state_d;
            conv_start_q <= conv_start_d;
            weight_en_q  <= weight_en_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        b_d          = b_q;
        wdog_d       = wdog_q;
        drain_d      = drain_q;
        err_d        = err_q;
        conv_state_d = conv_state_q;
        wt_rd_d      = 1'b0;
        wt_addr_d    = '0;
        layer_done_d = 1'b0;
        // A read issued this cycle returns next cycle, so its channel enable follows then
        weight_en_d  = wt_rd_q ? (NCH'(1) << ch_q) : '0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d      = S_LOAD;
                    conv_state_d = bus.cmd_layer;
                    err_d        = 1'b0;
                    ch_d         = '0;
                    b_d          = '0;
                    wt_rd_d      = 1'b1;
                    wt_addr_d    = bus.cmd_layer ? AW'(L1_BASE) : '0;
                end
            end

            S_LOAD: begin
                if (last_bit) begin
                    state_d = S_ARM;
                end else begin
                    wt_rd_d   = 1'b1;
                    // Kernels are contiguous in ROM, so the address simply increments
                    wt_addr_d = wt_addr_q + AW'(1);
                    if (b_q == B_W'(KBITS - 1)) begin
                        b_d  = '0;
                        ch_d = ch_q + CH_W'(1);
                    end else begin
                        b_d = b_q + B_W'(1);
                    end
                end
            end

            S_ARM: begin
                state_d = S_RUN;
                wdog_d  = '0;
            end

            S_RUN: begin
                // Completion takes priority over a same-cycle watchdog expiry
                if (&bus.conv_done) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end

            S_DRAIN: begin
                if (drain_q == DR_W'(DRAIN_CYC - 1)) begin
                    state_d      = S_DONE;
                    layer_done_d = 1'b1;
                end else begin
                    drain_d = drain_q + DR_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status and start levels are looked up from the state being entered
        cmd_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        conv_start_d = (state_d == S_RUN);
        if (state_d == S_IDLE) begin
            conv_state_d = 1'b0;
        end
    end

    assign bus.cmd_ready      = cmd_ready_q;
    assign bus.busy           = busy_q;
    assign bus.layer_done     = layer_done_q;
    assign bus.err_timeout    = err_q;
    assign bus.wt_rd          = wt_rd_q;
    assign bus.wt_addr        = wt_addr_q;
    assign bus.conv_state     = conv_state_q;
    assign bus.conv_start     = conv_start_q;
    assign bus.conv_weight_en = weight_en_q;
    // ROM data arrives in the same cycle as its registered enable; mask it otherwise
    assign bus.conv_weight    = bus.wt_rdata & (|weight_en_q);

endmodule

// File: tb/tb_conv_layer_seq.sv
// Self-checking bench for conv_layer_seq: random ROM contents and engine done patterns,
// a cycle-offset reference model compared every cycle, plus literal scenario checks.
module tb_conv_layer_seq;
    localparam int unsigned NCH       = 6;
    localparam int unsigned KBITS     = 25;
    localparam int unsigned AW        = 10;
    localparam int unsigned L1_BASE   = 150;
    localparam int unsigned DRAIN_CYC = 16;
    localparam int unsigned TIMEOUT   = 4095;
    localparam int          LOADN     = NCH * KBITS;
    localparam int          RUN_K     = LOADN + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_layer_seq_if #(.NCH(NCH), .AW(AW)) bus ();

    conv_layer_seq #(
        .NCH(NCH), .KBITS(KBITS), .AW(AW), .L1_BASE(L1_BASE),
        .DRAIN_CYC(DRAIN_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    bit rom [0:(1<<AW)-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Weight ROM: data valid the cycle after the read strobe, junk otherwise
    always @(posedge clk) bus.wt_rdata <= bus.wt_rd ? rom[bus.wt_addr] : 1'($urandom);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    bit m_on = 0, m_active = 0, m_layer = 0, m_err = 0;
    int m_acc = 0, m_done = -1;

    always @(negedge clk) begin
        int k, base;
        int e_ready, e_busy, e_ld, e_rd, e_addr, e_state, e_start, e_en, e_w;
        if (m_on) begin
            k = cyc - m_acc;
            base = m_layer ? int'(L1_BASE) : 0;
            e_ready = 1; e_busy = 0; e_ld = 0; e_rd = 0; e_addr = 0;
            e_state = 0; e_start = 0; e_en = 0; e_w = 0;
            if (m_active) begin
                e_ready = 0; e_busy = 1; e_state = int'(m_layer);
                if (k >= 1 && k <= LOADN) begin
                    e_rd = 1; e_addr = base + k - 1;
                end
                if (k >= 2 && k <= LOADN + 1) begin
                    e_en = 1 << ((k - 2) / int'(KBITS));
                    e_w  = int'(rom[base + k - 2]);
                end
                if (k >= RUN_K) begin
                    if (m_done < 0) e_start = 1;
                    else if (cyc - m_done == int'(DRAIN_CYC) + 1) e_ld = 1;
                end
            end
            chk("cmd_ready",      int'(bus.cmd_ready),      e_ready);
            chk("busy",           int'(bus.busy),           e_busy);
            chk("layer_done",     int'(bus.layer_done),     e_ld);
            chk("err_timeout",    int'(bus.err_timeout),    int'(m_err));
            chk("wt_rd",          int'(bus.wt_rd),          e_rd);
            chk("wt_addr",        int'(bus.wt_addr),        e_addr);
            chk("conv_state",     int'(bus.conv_state),     e_state);
            chk("conv_start",     int'(bus.conv_start),     e_start);
            chk("conv_weight_en", int'(bus.conv_weight_en), e_en);
            chk("conv_weight",    int'(bus.conv_weight),    e_w);
        end
        // advance model to the next cycle
        if (rst) begin
            m_on = 1; m_active = 0; m_err = 0; m_done = -1;
        end else if (m_on) begin
            k = cyc - m_acc;
            if (m_active) begin
                if (m_done < 0 && k >= RUN_K) begin
                    if (&bus.conv_done) m_done = cyc;
                    else if (k - RUN_K == int'(TIMEOUT) - 1) begin
                        m_active = 0; m_err = 1;
                    end
                end else if (m_done >= 0 && cyc - m_done == int'(DRAIN_CYC) + 1) begin
                    m_active = 0;
                end
            end else if (bus.cmd_valid) begin
                m_active = 1; m_acc = cyc; m_layer = bus.cmd_layer; m_err = 0; m_done = -1;
            end
        end
    end

    // ---------------- event recorder for literal checks ----------------
    int start_rise = -1, start_fall = -1, ld_cyc = -1, ld_cnt = 0, err_rise = -1;
    int rd_rise_addr = -1, en2_cnt = 0, en2_ones = 0, hs_cyc = -1;
    bit p_start = 0, p_err = 0, p_rd = 0;

    always @(negedge clk) begin
        if (bus.conv_start === 1'b1 && !p_start) start_rise = cyc;
        if (bus.conv_start === 1'b0 && p_start) start_fall = cyc;
        if (bus.layer_done === 1'b1) begin ld_cyc = cyc; ld_cnt++; end
        if (bus.err_timeout === 1'b1 && !p_err) err_rise = cyc;
        if (bus.wt_rd === 1'b1 && !p_rd) rd_rise_addr = int'(bus.wt_addr);
        if (bus.conv_weight_en[2] === 1'b1) begin
            en2_cnt++;
            en2_ones += int'(bus.conv_weight === 1'b1);
        end
        if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1 && !rst) hs_cyc = cyc;
        p_start = (bus.conv_start === 1'b1);
        p_err   = (bus.err_timeout === 1'b1);
        p_rd    = (bus.wt_rd === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit probe(input int which);
        case (which)
            0:       return bus.cmd_ready === 1'b1;
            1:       return bus.conv_start === 1'b1;
            2:       return bus.layer_done === 1'b1;
            3:       return bus.err_timeout === 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int limit, input string nm);
        int n = 0;
        while (!probe(which) && n < limit) begin
            tick(1);
            n++;
        end
        if (!probe(which)) begin
            checks++;
            $display("FAIL wait_%s: event absent after %0d cycles", nm, limit);
        end
    endtask

    task automatic send_cmd(input bit layer);
        wait_for(0, 5000, "ready");
        bus.cmd_valid = 1'b1;
        bus.cmd_layer = layer;
        tick(1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic rom_random();
        for (int i = 0; i < (1 << AW); i++) rom[i] = 1'($urandom);
    endtask

    task automatic partial_done();
        bus.conv_done = NCH'($urandom_range(0, (1 << NCH) - 2));
    endtask

    task automatic pulse_done();
        bus.conv_done = '1;
        tick(1);
        bus.conv_done = '0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int dc, ld0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_layer = 1'b0;
        bus.conv_done = '0;
        rom_random();
        tick(3);
        chk("rst_ready", int'(bus.cmd_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_weight_en", int'(bus.conv_weight_en), 0);
        rst = 1'b0;
        tick(2);

        // layer 0 with parity ROM; done asserted during LOAD must be ignored
        for (int i = 0; i < (1 << AW); i++) rom[i] = i[0];
        en2_cnt = 0; en2_ones = 0; ld0 = ld_cnt;
        send_cmd(1'b0);
        bus.conv_done = '1;
        tick(100);
        for (int n = 0; n < 200 && !probe(1); n++) begin partial_done(); tick(1); end
        repeat (30) begin partial_done(); tick(1); end
        pulse_done();
        wait_for(2, 40, "t2_done");
        tick(2);
        chk("t2_first_addr", rd_rise_addr, 0);
        chk("t2_ch2_beats", en2_cnt, 25);
        chk("t2_ch2_ones", en2_ones, 12);
        chk("t2_start_latency", start_rise - hs_cyc, 152);
        chk("t2_done_count", ld_cnt - ld0, 1);

        // layer 1: base address and mode bit
        rom_random();
        send_cmd(1'b1);
        wait_for(1, 200, "t3_start");
        chk("t3_first_addr", rd_rise_addr, 150);
        chk("t3_state_run", int'(bus.conv_state), 1);
        repeat ($urandom_range(1, 40)) begin partial_done(); tick(1); end
        pulse_done();
        wait_for(2, 40, "t3_done");
        tick(2);
        chk("t3_state_idle", int'(bus.conv_state), 0);

        // partial done for 50 cycles, then all channels done
        ld0 = ld_cnt;
        send_cmd(1'b0);
        wait_for(1, 200, "t4_start");
        bus.conv_done = 6'b111110;
        tick(50);
        bus.conv_done = '1;
        dc = cyc;
        tick(1);
        bus.conv_done = '0;
        wait_for(2, 40, "t4_done");
        tick(5);
        chk("t4_start_drop", start_fall - dc, 1);
        chk("t4_done_delay", ld_cyc - dc, 17);
        chk("t4_done_count", ld_cnt - ld0, 1);

        // watchdog abort, then the next command clears the error
        ld0 = ld_cnt;
        send_cmd(1'b0);
        bus.conv_done = '0;
        wait_for(3, RUN_K + int'(TIMEOUT) + 50, "t5_err");
        tick(1);
        chk("t5_timeout_len", err_rise - start_rise, 4095);
        chk("t5_no_done", ld_cnt - ld0, 0);
        chk("t5_busy", int'(bus.busy), 0);
        send_cmd(1'b1);
        chk("t5_err_cleared", int'(bus.err_timeout), 0);
        wait_for(1, 200, "t5_start");
        pulse_done();
        wait_for(2, 40, "t5_done");
        tick(1);

        // cmd_valid held high: back-to-back layers
        bus.cmd_valid = 1'b1;
        bus.cmd_layer = 1'($urandom_range(0, 1));
        wait_for(1, 300, "t6_start_a");
        tick($urandom_range(1, 20));
        pulse_done();
        wait_for(2, 40, "t6_done_a");
        tick(3);
        chk("t6_reaccept", hs_cyc - ld_cyc, 1);
        wait_for(1, 300, "t6_start_b");
        tick($urandom_range(1, 20));
        pulse_done();
        wait_for(2, 40, "t6_done_b");
        bus.cmd_valid = 1'b0;
        tick(3);

        // reset held 3 cycles in the middle of RUN
        send_cmd(1'b0);
        wait_for(1, 200, "t1_start");
        tick(10);
        rst = 1'b1;
        tick(1);
        chk("t1_start", int'(bus.conv_start), 0);
        chk("t1_busy", int'(bus.busy), 0);
        chk("t1_ready", int'(bus.cmd_ready), 1);
        chk("t1_weight_en", int'(bus.conv_weight_en), 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // random layers and done patterns
        for (int r = 0; r < 6; r++) begin
            rom_random();
            send_cmd(1'($urandom_range(0, 1)));
            wait_for(1, 200, "rnd_start");
            repeat ($urandom_range(0, 60)) begin partial_done(); tick(1); end
            pulse_done();
            wait_for(2, 40, "rnd_done");
            tick($urandom_range(1, 4));
        end

        tick(5);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
